// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NRD    = 2;
  localparam int DEF_BYPASS = 1;

  // Register-select width; never below one bit so ports stay legal.
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Width able to hold a count from 0 up to and including nregs.
  function automatic int calc_cw(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer,
// decides whether a new reservation may be taken (WAW stall otherwise)
// and keeps a running count of busy registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = calc_aw(NREGS),
  localparam int CW    = calc_cw(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_resvValid,
  input  logic [AW-1:0]    i_resvSel,
  output logic             o_resvReady,
  input  logic             i_wrValid,
  input  logic [AW-1:0]    i_wrSel,
  input  logic             i_flush,
  output logic [NREGS-1:0] o_busyVec,
  output logic [CW-1:0]    o_pendCount
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_hit;
  logic             resv_set;
  logic             cnt_inc;
  logic             cnt_dec;

  // Writebacks to register 0 are discarded and never touch the scoreboard.
  assign wr_hit = i_wrValid & (i_wrSel != '0);

  // A busy destination may be re-reserved only if its producer retires now.
  assign o_resvReady = (i_resvSel == '0) | ~busy_q[i_resvSel]
                     | (i_wrValid & (i_wrSel == i_resvSel));

  // Only accepted, nonzero reservations set a busy bit; flush blocks them.
  assign resv_set = i_resvValid & o_resvReady & ~i_flush & (i_resvSel != '0);

  // Per-register next busy: new producer wins over a same-cycle writeback.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_here, clr_here;
      assign set_here   = resv_set & (i_resvSel == AW'(gi));
      assign clr_here   = wr_hit & (i_wrSel == AW'(gi));
      assign busy_d[gi] = ~i_flush & (set_here | (busy_q[gi] & ~clr_here));
    end
  end

  // Incremental count tracks the 0->1 and 1->0 transitions of busy bits.
  assign cnt_inc = resv_set & ~busy_q[i_resvSel];
  assign cnt_dec = wr_hit & busy_q[i_wrSel]
                 & ~(resv_set & (i_resvSel == i_wrSel));

  // Next count: cleared by flush, otherwise adjusted by one in each direction.
  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign o_busyVec   = busy_q;
  assign o_pendCount = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a busy-bit scoreboard. Storage and the
// read/bypass muxes live here; reservation tracking is in the scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  parameter  int BYPASS = DEF_BYPASS,
  localparam int AW     = calc_aw(NREGS),
  localparam int CW     = calc_cw(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rdSel,
  output logic [NRD*XLEN-1:0] o_rdData,
  output logic [NRD-1:0]      o_rdBusy,
  input  logic                i_resvValid,
  input  logic [AW-1:0]       i_resvSel,
  output logic                o_resvReady,
  input  logic                i_wrValid,
  input  logic [AW-1:0]       i_wrSel,
  input  logic [XLEN-1:0]     i_wrData,
  input  logic                i_flush,
  output logic [NREGS-1:0]    o_busyVec,
  output logic [CW-1:0]       o_pendCount
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage: nonzero writebacks land on the next edge; register 0 stays 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (i_wrValid && (i_wrSel == AW'(r))) begin
          regs_q[r] <= i_wrData;
        end
      end
    end
  end

  // Combinational read ports with optional same-cycle writeback forwarding.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] sel;
    logic          nz;
    logic          byp;
    assign sel = i_rdSel[gi*AW +: AW];
    assign nz  = (sel != '0);
    assign byp = (BYPASS != 0) & i_wrValid & (i_wrSel == sel) & nz;
    assign o_rdData[gi*XLEN +: XLEN] = !nz ? '0 : (byp ? i_wrData : regs_q[sel]);
    assign o_rdBusy[gi] = nz & ~byp & o_busyVec[sel];
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_resvValid (i_resvValid),
    .i_resvSel   (i_resvSel),
    .o_resvReady (o_resvReady),
    .i_wrValid   (i_wrValid),
    .i_wrSel     (i_wrSel),
    .i_flush     (i_flush),
    .o_busyVec   (o_busyVec),
    .o_pendCount (o_pendCount)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1; 1 forwards same-cycle writeback data to reads.
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_rdSel  in  NRD*AW  read register selects, port k at bits [k*AW +: AW].
REQ-008 o_rdData  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-009 o_rdBusy  out  NRD  port k's register has an outstanding producer.
REQ-010 i_resvValid  in  1  issue request to reserve a destination.
REQ-011 i_resvSel  in  AW  destination register to reserve.
REQ-012 o_resvReady  out  1  reservation can be accepted this cycle.
REQ-013 i_wrValid  in  1  writeback valid.
REQ-014 i_wrSel  in  AW  writeback register.
REQ-015 i_wrData  in  XLEN  writeback data.
REQ-016 i_flush  in  1  clear all reservations (pipeline flush).
REQ-017 o_busyVec  out  NREGS  registered busy bit per register.
REQ-018 o_pendCount  out  $clog2(NREGS+1)  registered count of set busy bits.

Function
REQ-019 Reads SHALL be combinational; register 0 SHALL read 0 and never report busy.
REQ-020 With BYPASS=1, a read port whose select equals i_wrSel while i_wrValid=1 and select!=0 SHALL return i_wrData and o_rdBusy=0 that cycle.
REQ-021 With BYPASS=0, a read SHALL return stored contents, and o_rdBusy SHALL equal the stored busy bit.
REQ-022 A writeback with i_wrValid=1 and i_wrSel!=0 SHALL update the register on the next edge and clear its busy bit; writes to register 0 SHALL be dropped.
REQ-023 Writeback to a non-busy register SHALL be legal: data updated, busy unchanged.
REQ-024 o_resvReady = (i_resvSel==0) | !busy[i_resvSel] | (i_wrValid & i_wrSel==i_resvSel); combinational; WAW stall otherwise.
REQ-025 A reservation is accepted when i_resvValid & o_resvReady & !i_flush; accepted nonzero i_resvSel SHALL set busy on the next edge; reservation of register 0 SHALL be accepted with no effect.
REQ-026 Same-cycle accepted reservation and writeback to one register: data written, busy ends 1 (new producer wins).
REQ-027 i_flush=1 SHALL clear all busy bits on the next edge and block reservation that cycle; a same-cycle writeback SHALL still write data.
REQ-028 o_pendCount SHALL update incrementally (+1 set, -1 clear, net 0 if both on one register) and SHALL equal popcount(o_busyVec) every cycle; flush sets it to 0.
REQ-029 Without a flush, a reservation followed by a writeback with no other activity SHALL return o_pendCount to its prior value.

Reset
REQ-030 i_rst_n=0 SHALL asynchronously clear all registers to 0, o_busyVec to 0, o_pendCount to 0.
REQ-031 Reset mid-operation SHALL discard all pending reservations; the first edge after deassertion SHALL process inputs normally.

Structure
REQ-032 Default parameter values and the AW/count width helper functions SHALL live in shared package regfile_pkg.
REQ-033 Busy bits, ready logic and o_pendCount SHALL be a sub-module regfile_scoreboard; storage and read/bypass muxing SHALL stay at top.

Verification
REQ-034 Reset, then write x5=0xDEADBEEF; next cycle read port0=5 -> 0xDEADBEEF; read 0 -> 0 after write x0=0x1.
REQ-035 Reserve x7 -> o_busyVec[7]=1, o_pendCount=1; re-reserve x7 -> o_resvReady=0; writeback x7=0x55 -> busy 0, count 0.
REQ-036 BYPASS=1: writeback x3=0xA5A5 while port1 reads 3 -> o_rdData port1=0xA5A5, o_rdBusy[1]=0 the same cycle.
REQ-037 Same-cycle reserve x4 and writeback x4=0x11 -> x4=0x11, busy[4]=1, count unchanged net +0 from busy state.
REQ-038 Reserve x1,x2,x3, then flush plus reserve x9 -> busyVec=0, count=0, x9 not busy.
REQ-039 Assert i_rst_n=0 asynchronously with 3 regs busy -> all outputs 0 immediately, before the next clock edge.
